adder_resp_checker: RTL

ADDER_RESP_CHECKER -- requirements
Module: adder_resp_checker

---
 rtl/adder_resp_checker_if.sv | 18 +
 rtl/adder_resp_checker.sv | 99 +++++++++
 2 files changed

// File: rtl/adder_resp_checker_if.sv
// Vector handshake bus between the adder harness (master) and the checker (slave).
//   in_valid / in_ready : transfer handshake, a vector moves when both are high
//   a, b, cin           : operands applied to the adder under check
//   sum, cout           : adder response observed for those operands
interface adder_resp_checker_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output in_valid, a, b, cin, sum, cout, input in_ready);
  modport slave  (input in_valid, a, b, cin, sum, cout, output in_ready);
endinterface

// File: rtl/adder_resp_checker.sv
// Checks observed adder responses against a + b + cin, one vector per transfer.
// Ports:
//   clk, rst       : rising-edge clock, asynchronous active-high reset
//   clr            : synchronous run restart (clears counters and status)
//   bus            : vector handshake (slave side)
//   chk_valid/pass : one-cycle check result, one cycle after each transfer
//   pass_cnt/fail_cnt : saturating tallies; vec_cnt : vectors accepted this run
//   err_any, fail_idx, exp_first : sticky first-failure record
//   done           : run complete, held until clr or rst
module adder_resp_checker #(
  parameter int WIDTH       = 4,
  parameter int NUM_VECTORS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  adder_resp_checker_if.slave  bus,
  output logic                 chk_valid,
  output logic                 chk_pass,
  output logic [7:0]           pass_cnt,
  output logic [7:0]           fail_cnt,
  output logic [7:0]           vec_cnt,
  output logic                 err_any,
  output logic [7:0]           fail_idx,
  output logic [WIDTH:0]       exp_first,
  output logic                 done
);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  localparam logic [7:0] LAST = 8'(NUM_VECTORS - 1);

  state_t         state;
  logic           xfer;
  logic [WIDTH:0] expv;
  logic           match;

  assign bus.in_ready = (state == RUN);
  // A vector arriving together with clr belongs to the abandoned run.
  assign xfer  = bus.in_valid & bus.in_ready & ~clr;
  // Full WIDTH+1 result so the carry is checked, not truncated.
  assign expv  = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
  assign match = (expv == {bus.cout, bus.sum});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      chk_valid <= 1'b0;
      chk_pass  <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      vec_cnt   <= '0;
      err_any   <= 1'b0;
      fail_idx  <= '0;
      exp_first <= '0;
      done      <= 1'b0;
    end else if (clr) begin
      state     <= RUN;
      chk_valid <= 1'b0;
      chk_pass  <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      vec_cnt   <= '0;
      err_any   <= 1'b0;
      fail_idx  <= '0;
      exp_first <= '0;
      done      <= 1'b0;
    end else begin
      // Result and tallies land on the transfer edge, so counters move in
      // the same cycle chk_valid is seen.
      chk_valid <= xfer;
      case (state)
        RUN: begin
          // done rises alongside the final chk_valid.
          if (xfer && vec_cnt == LAST) begin
            state <= DRAIN;
            done  <= 1'b1;
          end
        end
        DRAIN:   state <= DONE;
        DONE:    state <= DONE;
        default: state <= RUN;
      endcase
      if (xfer) begin
        chk_pass <= match;
        vec_cnt  <= vec_cnt + 8'd1;
        if (match) begin
          if (pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 8'd1;
        end else begin
          if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
          if (!err_any) begin
            err_any   <= 1'b1;
            fail_idx  <= vec_cnt;
            exp_first <= expv;
          end
        end
      end
    end
  end
endmodule
